// File: rtl/stream_write_arbiter.sv
// Round-robin arbiter that grants one requester at a time a burst of up to
// BURST_MAX cache lines onto a single registered write stream.
module stream_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned BURST_MAX  = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0][2:0]              req_buffer,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic                                 wr_full,
  output logic                                 wr_valid,
  output logic [2:0]                           wr_buffer,
  output logic [DATA_WIDTH-1:0]                wr_data,
  output logic [2:0]                           grant_id,
  output logic                                 busy,
  output logic [31:0]                          lines_sent
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] NREQ4     = 4'(NUM_REQ);
  localparam logic [2:0] LAST_IDX  = 3'(NUM_REQ - 1);
  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

  state_t state, state_next;
  logic [2:0] rr_ptr, owner, pick;
  logic [3:0] slot;
  logic       pick_found;
  logic [7:0] burst_cnt;
  logic       xfer, burst_done, leave_grant;

  // Requester vectors padded to 8 entries so the 3-bit owner indexes them directly.
  logic [7:0]                 valid_pad;
  logic [7:0][DATA_WIDTH-1:0] data_pad;
  logic [7:0][2:0]            buf_pad;

  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < NUM_REQ) begin : g_used
      assign valid_pad[g] = req_valid[g];
      assign data_pad[g]  = req_data[g];
      assign buf_pad[g]   = req_buffer[g];
    end else begin : g_unused
      assign valid_pad[g] = 1'b0;
      assign data_pad[g]  = '0;
      assign buf_pad[g]   = '0;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
    assign req_ready[g] = (state == GRANT) && !wr_full && (owner == 3'(g));
  end

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    slot       = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      slot = {1'b0, rr_ptr} + 4'(j);
      if (slot >= NREQ4) slot = slot - NREQ4;
      if (!pick_found && valid_pad[slot[2:0]]) begin
        pick_found = 1'b1;
        pick       = slot[2:0];
      end
    end
  end

  assign xfer        = (state == GRANT) && !wr_full && valid_pad[owner];
  assign burst_done  = xfer && ((burst_cnt + 8'd1) == BURST_LIM);
  assign leave_grant = (state == GRANT) && ((!wr_full && !valid_pad[owner]) || burst_done);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found) state_next = GRANT;
      GRANT:   if (leave_grant) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= '0;
      rr_ptr     <= '0;
      burst_cnt  <= '0;
      wr_valid   <= 1'b0;
      wr_data    <= '0;
      wr_buffer  <= '0;
      lines_sent <= '0;
    end else begin
      if (state == IDLE && pick_found) begin
        owner     <= pick;
        burst_cnt <= '0;
      end else if (xfer) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
      if (leave_grant) rr_ptr <= (owner == LAST_IDX) ? 3'd0 : owner + 3'd1;
      wr_valid <= xfer;
      if (xfer) begin
        wr_data    <= data_pad[owner];
        wr_buffer  <= buf_pad[owner];
        lines_sent <= lines_sent + 32'd1;
      end
    end
  end

  assign grant_id = owner;
  assign busy     = (state == GRANT);

endmodule

// File: tb/tb_stream_write_arbiter.sv
// Self-checking bench for stream_write_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_stream_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0][2:0]    req_buffer;
  logic                 wr_full;

  logic [N-1:0]  rdy_a, rdy_b;
  logic          wv_a, wv_b, busy_a, busy_b;
  logic [2:0]    wb_a, wb_b, gid_a, gid_b;
  logic [DW-1:0] wd_a, wd_b;
  logic [31:0]   ls_a, ls_b;

  int n_cmp = 0;
  int n_err = 0;

  stream_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_buffer(req_buffer), .req_ready(rdy_a), .wr_full(wr_full), .wr_valid(wv_a),
    .wr_buffer(wb_a), .wr_data(wd_a), .grant_id(gid_a), .busy(busy_a), .lines_sent(ls_a)
  );

  stream_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_buffer(req_buffer), .req_ready(rdy_b), .wr_full(wr_full), .wr_valid(wv_b),
    .wr_buffer(wb_b), .wr_data(wd_b), .grant_id(gid_b), .busy(busy_b), .lines_sent(ls_b)
  );

  // Reference model, index 0 mirrors dut_a (burst 16), index 1 dut_b (burst 4).
  int            bmax [2] = '{16, 4};
  bit            m_busy [2];
  int            m_owner [2];
  int            m_cnt [2];
  int            m_ptr [2];
  logic [31:0]   m_lines [2];
  bit            m_wv [2];
  logic [DW-1:0] m_wd [2];
  logic [2:0]    m_wb [2];

  always @(posedge clk or negedge reset_n) begin : model
    bit go;
    int cand;
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_owner[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
        m_lines[k] = '0; m_wv[k] = 0; m_wd[k] = '0; m_wb[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!m_busy[k]) begin
          m_wv[k] = 0;
          for (int j = 0; j < N; j++) begin
            cand = (m_ptr[k] + j) % N;
            if (!m_busy[k] && req_valid[cand]) begin
              m_busy[k]  = 1;
              m_owner[k] = cand;
              m_cnt[k]   = 0;
            end
          end
        end else begin
          go = !wr_full && req_valid[m_owner[k]];
          m_wv[k] = go;
          if (go) begin
            m_wd[k]    = req_data[m_owner[k]];
            m_wb[k]    = req_buffer[m_owner[k]];
            m_lines[k] = m_lines[k] + 1;
            m_cnt[k]   = m_cnt[k] + 1;
          end
          if ((!wr_full && !req_valid[m_owner[k]]) || (go && m_cnt[k] == bmax[k])) begin
            m_busy[k] = 0;
            m_ptr[k]  = (m_owner[k] + 1) % N;
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] dval(input int req, input int n);
    return DW'(32'hA000_0000 + req * 32'h0001_0000 + n);
  endfunction

  task automatic do_reset;
    @(negedge clk);
    reset_n = 1'b0; req_valid = '0; wr_full = 1'b0; req_data = '0; req_buffer = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    req_valid = '1;
    #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0h want 0", busy_a); end
    n_cmp++; if (wv_a !== 1'b0) begin n_err++; $display("FAIL reset_wr_valid: got %0h want 0", wv_a); end
    n_cmp++; if (wd_a !== '0) begin n_err++; $display("FAIL reset_wr_data: got %0h want 0", wd_a); end
    n_cmp++; if (wb_a !== 3'd0) begin n_err++; $display("FAIL reset_wr_buffer: got %0h want 0", wb_a); end
    n_cmp++; if (gid_a !== 3'd0) begin n_err++; $display("FAIL reset_grant_id: got %0h want 0", gid_a); end
    n_cmp++; if (ls_a !== 32'd0) begin n_err++; $display("FAIL reset_lines_sent: got %0h want 0", ls_a); end
    n_cmp++; if (rdy_a !== '0) begin n_err++; $display("FAIL reset_req_ready: got %0h want 0", rdy_a); end
    n_cmp++;
    if ({busy_b, wv_b, wd_b, wb_b, gid_b, ls_b, rdy_b} !== '0) begin
      n_err++; $display("FAIL reset_dut_b: got %0h want 0", {busy_b, wv_b, wd_b, wb_b, gid_b, ls_b, rdy_b});
    end
    @(posedge clk); #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_held_busy: got %0h want 0", busy_a); end
  endtask

  task automatic test_single;
    int sent, got;
    bit acc;
    do_reset;
    req_valid = 4'b0100; req_data[2] = dval(2, 0); req_buffer[2] = 3'd5;
    @(posedge clk); #1;
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL single_busy: got %0h want 1", busy_a); end
    n_cmp++; if (gid_a !== 3'd2) begin n_err++; $display("FAIL single_grant: got %0h want 2", gid_a); end
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      @(negedge clk);
      if (sent < 5) begin req_valid[2] = 1'b1; req_data[2] = dval(2, sent); end
      else req_valid[2] = 1'b0;
      #1;
      if (sent < 5) begin
        n_cmp++; if (rdy_a !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %0h want 4", rdy_a); end
      end
      acc = rdy_a[2] && req_valid[2];
      @(posedge clk); #1;
      if (acc) sent++;
      n_cmp++; if (wv_a !== acc) begin n_err++; $display("FAIL single_wr_valid: got %0h want %0h", wv_a, acc); end
      if (wv_a) begin
        n_cmp++; if (wd_a !== dval(2, got)) begin n_err++; $display("FAIL single_wr_data: got %0h want %0h", wd_a, dval(2, got)); end
        n_cmp++; if (wb_a !== 3'd5) begin n_err++; $display("FAIL single_wr_buffer: got %0h want 5", wb_a); end
        got++;
      end
    end
    n_cmp++; if (got !== 5) begin n_err++; $display("FAIL single_count: got %0d want 5", got); end
    n_cmp++; if (ls_a !== 32'd5) begin n_err++; $display("FAIL single_lines_sent: got %0d want 5", ls_a); end
    @(negedge clk); req_valid = '0;
    @(posedge clk); #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL single_idle: got %0h want 0", busy_a); end
  endtask

  task automatic test_fairness;
    int cnt [N];
    int order [5] = '{0, 1, 2, 3, 0};
    int grants, in_grant, idle_run, acc_idx;
    bit prev_busy;
    logic [DW-1:0] acc_data;
    do_reset;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    grants = 0; in_grant = 0; idle_run = 0; prev_busy = 0; acc_data = '0;
    req_valid = '1;
    for (int cyc = 0; cyc < 40 && grants < 5; cyc++) begin
      if (cyc > 0) @(negedge clk);
      for (int i = 0; i < N; i++) begin req_data[i] = dval(i, cnt[i]); req_buffer[i] = 3'(i); end
      #1;
      acc_idx = -1;
      for (int i = 0; i < N; i++) if (rdy_b[i] && req_valid[i]) begin acc_idx = i; acc_data = req_data[i]; end
      @(posedge clk); #1;
      if (acc_idx >= 0) begin cnt[acc_idx]++; in_grant++; end
      n_cmp++; if (wv_b !== (acc_idx >= 0)) begin n_err++; $display("FAIL fair_wr_valid: got %0h want %0h", wv_b, acc_idx >= 0); end
      if (acc_idx >= 0) begin
        n_cmp++; if (wd_b !== acc_data) begin n_err++; $display("FAIL fair_wr_data: got %0h want %0h", wd_b, acc_data); end
      end
      if (busy_b && !prev_busy) begin
        n_cmp++; if (gid_b !== 3'(order[grants])) begin n_err++; $display("FAIL fair_order: got %0d want %0d", gid_b, order[grants]); end
        if (grants > 0) begin
          n_cmp++; if (idle_run !== 1) begin n_err++; $display("FAIL fair_idle_gap: got %0d want 1", idle_run); end
        end
        in_grant = 0; idle_run = 0;
      end else if (!busy_b && prev_busy) begin
        n_cmp++; if (in_grant !== 4) begin n_err++; $display("FAIL fair_burst_len: got %0d want 4", in_grant); end
        grants++;
      end
      if (!busy_b) idle_run++;
      prev_busy = busy_b;
    end
    n_cmp++; if (grants !== 5) begin n_err++; $display("FAIL fair_grants: got %0d want 5", grants); end
    n_cmp++; if (ls_b !== 32'd20) begin n_err++; $display("FAIL fair_lines_sent: got %0d want 20", ls_b); end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    int sent, got, stall;
    bit acc, checked;
    do_reset;
    req_valid = 4'b0010; req_data[1] = dval(1, 0); req_buffer[1] = 3'd3;
    @(posedge clk); #1;
    sent = 0; got = 0; stall = 0; checked = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      wr_full = (sent == 3 && stall < 3);
      if (wr_full) stall++;
      req_valid[1] = (sent < 8);
      req_data[1]  = dval(1, sent);
      #1;
      if (wr_full) begin
        n_cmp++; if (rdy_a !== '0) begin n_err++; $display("FAIL bp_ready_stall: got %0h want 0", rdy_a); end
      end
      acc = rdy_a[1] && req_valid[1];
      @(posedge clk); #1;
      if (acc) sent++;
      n_cmp++; if (wv_a !== acc) begin n_err++; $display("FAIL bp_wr_valid: got %0h want %0h", wv_a, acc); end
      if (wv_a) begin
        n_cmp++; if (wd_a !== dval(1, got)) begin n_err++; $display("FAIL bp_wr_data: got %0h want %0h", wd_a, dval(1, got)); end
        got++;
      end
      if (stall == 3 && !checked) begin
        checked = 1;
        n_cmp++; if (dut_a.burst_cnt !== 8'd3) begin n_err++; $display("FAIL bp_burst_cnt: got %0d want 3", dut_a.burst_cnt); end
        n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL bp_busy: got %0h want 1", busy_a); end
      end
    end
    wr_full = 1'b0;
    n_cmp++; if (got !== 8) begin n_err++; $display("FAIL bp_count: got %0d want 8", got); end
    n_cmp++; if (ls_a !== 32'd8) begin n_err++; $display("FAIL bp_lines_sent: got %0d want 8", ls_a); end
    req_valid = '0;
  endtask

  task automatic test_wrap;
    bit seen_idle, found;
    logic [2:0] second;
    do_reset;
    req_valid = 4'b0100;
    @(posedge clk); #1;
    n_cmp++; if (gid_b !== 3'd2) begin n_err++; $display("FAIL wrap_setup: got %0d want 2", gid_b); end
    @(negedge clk); req_valid = 4'b1001;
    @(posedge clk); #1;
    n_cmp++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL wrap_release: got %0h want 0", busy_b); end
    @(posedge clk); #1;
    n_cmp++; if (gid_b !== 3'd3 || busy_b !== 1'b1) begin n_err++; $display("FAIL wrap_first: got %0d want 3", gid_b); end
    seen_idle = 0; found = 0; second = '0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(posedge clk); #1;
      if (!busy_b) seen_idle = 1;
      else if (seen_idle) begin found = 1; second = gid_b; end
    end
    n_cmp++; if (!found || second !== 3'd0) begin n_err++; $display("FAIL wrap_second: got %0d want 0 (found=%0d)", second, found); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid;
    int sent;
    bit acc;
    do_reset;
    req_valid = 4'b0100; req_buffer[2] = 3'd6; req_data[2] = dval(2, 0);
    @(posedge clk); #1;
    sent = 0;
    for (int cyc = 0; cyc < 20 && sent < 3; cyc++) begin
      @(negedge clk); req_data[2] = dval(2, sent);
      #1; acc = rdy_a[2];
      @(posedge clk); #1;
      if (acc) sent++;
    end
    n_cmp++; if (wv_a !== 1'b1) begin n_err++; $display("FAIL rmid_line_pending: got %0h want 1", wv_a); end
    #2; reset_n = 1'b0; req_valid = 4'b0101; req_data[0] = dval(0, 0);
    #1;
    n_cmp++;
    if ({wv_a, wd_a, wb_a, busy_a, gid_a, ls_a, rdy_a} !== '0) begin
      n_err++; $display("FAIL rmid_async_clear: got %0h want 0", {wv_a, wd_a, wb_a, busy_a, gid_a, ls_a, rdy_a});
    end
    @(posedge clk); @(negedge clk); reset_n = 1'b1;
    #1;
    n_cmp++; if (ls_a !== 32'd0) begin n_err++; $display("FAIL rmid_lines_sent: got %0d want 0", ls_a); end
    @(posedge clk); #1;
    n_cmp++; if (busy_a !== 1'b1 || gid_a !== 3'd0) begin n_err++; $display("FAIL rmid_regrant: got %0d want 0", gid_a); end
    @(posedge clk); #1;
    n_cmp++; if (ls_a !== 32'd1 || wd_a !== dval(0, 0)) begin n_err++; $display("FAIL rmid_first_line: got %0d/%0h want 1/%0h", ls_a, wd_a, dval(0, 0)); end
    req_valid = '0;
  endtask

  task automatic test_counter_wrap;
    do_reset;
    force dut_a.lines_sent = 32'hFFFF_FFFF;
    #1;
    release dut_a.lines_sent;
    #1;
    n_cmp++; if (ls_a !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preload: got %0h want ffffffff", ls_a); end
    req_valid = 4'b0001; req_data[0] = dval(0, 7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (ls_a !== 32'd0 || wv_a !== 1'b1) begin n_err++; $display("FAIL counter_wrap: got %0h want 0", ls_a); end
    req_valid = '0;
  endtask

  task automatic test_random;
    logic [N-1:0] exp_rdy;
    do_reset;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      reset_n = 1'b1;
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin req_data[i] = DW'($urandom); req_buffer[i] = 3'($urandom); end
      wr_full = ($urandom_range(0, 3) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        exp_rdy = (m_busy[k] && !wr_full) ? N'(1 << m_owner[k]) : '0;
        n_cmp++;
        if ((k == 0 ? rdy_a : rdy_b) !== exp_rdy) begin
          n_err++; $display("FAIL rnd_ready[%0d]: got %0h want %0h", k, k == 0 ? rdy_a : rdy_b, exp_rdy);
        end
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({wv_a, wd_a, wb_a, busy_a, ls_a} !== {m_wv[0], m_wd[0], m_wb[0], m_busy[0], m_lines[0]}) begin
        n_err++; $display("FAIL rnd_out_a: got %0h/%0h/%0h/%0h/%0h want %0h/%0h/%0h/%0h/%0h",
          wv_a, wd_a, wb_a, busy_a, ls_a, m_wv[0], m_wd[0], m_wb[0], m_busy[0], m_lines[0]);
      end
      n_cmp++;
      if ({wv_b, wd_b, wb_b, busy_b, ls_b} !== {m_wv[1], m_wd[1], m_wb[1], m_busy[1], m_lines[1]}) begin
        n_err++; $display("FAIL rnd_out_b: got %0h/%0h/%0h/%0h/%0h want %0h/%0h/%0h/%0h/%0h",
          wv_b, wd_b, wb_b, busy_b, ls_b, m_wv[1], m_wd[1], m_wb[1], m_busy[1], m_lines[1]);
      end
      if (m_busy[0]) begin
        n_cmp++; if (gid_a !== 3'(m_owner[0])) begin n_err++; $display("FAIL rnd_grant_a: got %0d want %0d", gid_a, m_owner[0]); end
      end
      if (m_busy[1]) begin
        n_cmp++; if (gid_b !== 3'(m_owner[1])) begin n_err++; $display("FAIL rnd_grant_b: got %0d want %0d", gid_b, m_owner[1]); end
      end
      if (cyc == 150) begin
        #1; reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy_a, wv_a, ls_a, busy_b, wv_b, ls_b} !== '0) begin
          n_err++; $display("FAIL rnd_async_reset: got %0h want 0", {busy_a, wv_a, ls_a, busy_b, wv_b, ls_b});
        end
      end
    end
    req_valid = '0; wr_full = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = '0; req_data = '0; req_buffer = '0; wr_full = 1'b0;
    test_reset;
    test_single;
    test_fairness;
    test_backpressure;
    test_wrap;
    test_reset_mid;
    test_counter_wrap;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
